// File: rtl/norz_seq_pkg.sv
// Shared types and constants for the cycle sequencer that feeds the I-table decoder tree.
package norz_seq_pkg;

  typedef enum logic [1:0] {
    CYC_CM1 = 2'd0,
    CYC_CMR = 2'd1,
    CYC_CMW = 2'd2
  } norz_cycle_e;

  localparam int          XPT_W    = 4;
  localparam logic [3:0]  XPT_MAX  = 4'd15;
  localparam logic [3:0]  WAIT_T   = 4'd1;
  localparam int          ITABLE_W = 8;

endpackage

// File: rtl/norz_xpt_counter.sv
// T-state counter: synchronous clear, hold, saturate at XPT_MAX with a sticky overflow flag.
module norz_xpt_counter
  import norz_seq_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             hold,
  output logic [XPT_W-1:0] count,
  output logic             overflow
);

  logic [XPT_W-1:0] count_reg;
  logic             overflow_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (clear) begin
      count_reg    <= '0;
    end else if (hold) begin
      count_reg    <= count_reg;
    end else if (count_reg == XPT_MAX) begin
      // Saturate rather than wrap so a missing PR_Reset_XPT stays visible.
      overflow_reg <= 1'b1;
    end else begin
      count_reg    <= count_reg + 1'b1;
    end
  end

  assign count    = count_reg;
  assign overflow = overflow_reg;

endmodule

// File: rtl/norz_cycle_sequencer.sv
// Sequencing state for the I-table decoders: XPT, ITABLE, opcode pair and machine-cycle FSM.
// Wait-state insertion on mem_ready is built only when NORZ_WAIT_STATE_EN is defined.
module norz_cycle_sequencer
  import norz_seq_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                PR_Reset_XPT,
  input  logic                P2_Set_CM1,
  input  logic                P2_Set_CMR,
  input  logic                P2_Set_CMW,
  input  logic                P2_Set_ITABLE,
  input  logic                P2_Reset_ITABLE,
  input  logic [ITABLE_W-1:0] ITABLE_next,
  input  logic                Pa_Ophd,
  input  logic [7:0]          DBUS,
  input  logic                mem_ready,
  output logic [XPT_W-1:0]    XPT,
  output logic [XPT_W-1:0]    notXPT,
  output logic [ITABLE_W-1:0] ITABLE,
  output logic [ITABLE_W-1:0] notITABLE,
  output logic [7:0]          OP,
  output logic [7:0]          OPOPold,
  output logic                CM1,
  output logic                CMR,
  output logic                CMW,
  output logic                decode_enable,
  output logic                xpt_overflow
);

  norz_cycle_e         state_reg, state_next;
  logic                run_reg;
  logic [ITABLE_W-1:0] itable_reg, itable_next;
  logic [7:0]          op_reg, opold_reg;
  logic [XPT_W-1:0]    xpt_value;
  logic                stall;

`ifdef NORZ_WAIT_STATE_EN
  assign stall = (xpt_value == WAIT_T) & ~mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign stall            = 1'b0;
`endif

  norz_xpt_counter u_xpt_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (run_reg & PR_Reset_XPT),
    .hold     (stall),
    .count    (xpt_value),
    .overflow (xpt_overflow)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= CYC_CM1;
      run_reg    <= 1'b0;
      itable_reg <= '0;
      op_reg     <= '0;
      opold_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      run_reg    <= 1'b1;
      itable_reg <= itable_next;
      if (run_reg && Pa_Ophd) begin
        opold_reg <= op_reg;
        op_reg    <= DBUS;
      end
    end
  end

  // Strobes are meaningless until the first post-reset cycle, so run_reg gates them all.
  always_comb begin
    state_next  = state_reg;
    itable_next = itable_reg;
    if (run_reg) begin
      if (P2_Set_CM1)      state_next = CYC_CM1;
      else if (P2_Set_CMR) state_next = CYC_CMR;
      else if (P2_Set_CMW) state_next = CYC_CMW;

      if (P2_Set_ITABLE)        itable_next = ITABLE_next;
      else if (P2_Reset_ITABLE) itable_next = '0;
    end
  end

  assign XPT           = xpt_value;
  assign notXPT        = ~xpt_value;
  assign ITABLE        = itable_reg;
  assign notITABLE     = ~itable_reg;
  assign OP            = op_reg;
  assign OPOPold       = opold_reg;
  assign CM1           = (state_reg == CYC_CM1);
  assign CMR           = (state_reg == CYC_CMR);
  assign CMW           = (state_reg == CYC_CMW);
  assign decode_enable = run_reg & ~stall;

endmodule
